// File: rtl/uart_defs.sv
// Shared definitions for the UART receive FIFO: control FSM encodings and
// default word width.
package uart_defs;

    localparam int DB_DEF = 8;

    localparam logic [1:0] FIFO_EMPTY   = 2'b00;
    localparam logic [1:0] FIFO_PARTIAL = 2'b01;
    localparam logic [1:0] FIFO_FULL    = 2'b10;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and status control for the UART RX FIFO.
// Owns the EMPTY/PARTIAL/FULL FSM; the storage lives in the parent.
module fifo_ptr_ctrl
    import uart_defs::*;
#(
    parameter int W        = 2,
    parameter int AF_LEVEL = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clr_ovf,
    output logic         wr_en,
    output logic [W-1:0] wr_ptr,
    output logic [W-1:0] rd_ptr,
    output logic [W:0]   count,
    output logic         rx_empty,
    output logic         rx_full,
    output logic         almost_full,
    output logic         overflow
);

    localparam int           DEPTH_I = 1 << W;
    localparam logic [W:0]   DEPTH   = DEPTH_I[W:0];
    localparam logic [W:0]   AF_W    = AF_LEVEL[W:0];
    localparam logic [W:0]   CNT_ONE = 1;
    localparam logic [W-1:0] PTR_ONE = 1;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] wr_ptr_q, wr_ptr_d;
    logic [W-1:0] rd_ptr_q, rd_ptr_d;
    logic [W:0]   count_q, count_d;
    logic         empty_q, empty_d;
    logic         full_q, full_d;
    logic         af_q, af_d;
    logic         ovf_q, ovf_d;
    logic         push_ok, pop_ok;
    logic         wr_inc, rd_inc;

    // A push into a full FIFO is still accepted when a pop frees the head slot.
    always_comb begin
        push_ok = push & (~full_q | pop);
        pop_ok  = pop & ~empty_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FIFO_EMPTY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FIFO_EMPTY: begin
                if (push_ok) state_d = FIFO_PARTIAL;
            end
            FIFO_PARTIAL: begin
                if (pop_ok && !push_ok && count_q == CNT_ONE)
                    state_d = FIFO_EMPTY;
                else if (push_ok && !pop_ok && count_q == DEPTH - CNT_ONE)
                    state_d = FIFO_FULL;
            end
            FIFO_FULL: begin
                if (pop_ok && !push_ok) state_d = FIFO_PARTIAL;
            end
            default: state_d = FIFO_EMPTY;
        endcase
    end

    always_comb begin
        wr_en  = push_ok;
        wr_inc = push_ok;
        rd_inc = pop_ok && (state_q != FIFO_EMPTY);
    end

    always_comb begin
        wr_ptr_d = wr_inc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_inc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        case ({wr_inc, rd_inc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH);
        af_d    = (count_d >= AF_W);
        // A dropped word outranks a clear in the same cycle.
        ovf_d   = (push & ~push_ok) | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        wr_ptr      = wr_ptr_q;
        rd_ptr      = rd_ptr_q;
        count       = count_q;
        rx_empty    = empty_q;
        rx_full     = full_q;
        almost_full = af_q;
        overflow    = ovf_q;
    end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive FIFO: first-word-fall-through storage of {rx_err, data}
// entries with full/almost-full/count status and sticky overflow.
module uart_rx_fifo_ctrl
    import uart_defs::*;
#(
    parameter int DB       = DB_DEF,
    parameter int W        = 2,
    parameter int AF_LEVEL = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DB-1:0] d_out,
    input  logic          rx_err,
    input  logic          rx_done,
    input  logic          rd,
    input  logic          clr_ovf,
    output logic [DB-1:0] r_data,
    output logic          r_err,
    output logic          rx_empty,
    output logic          rx_full,
    output logic          almost_full,
    output logic          overflow,
    output logic [W:0]    count
);

    localparam int DEPTH = 1 << W;

    logic [DB:0]  mem_q [DEPTH];
    logic         wr_en;
    logic [W-1:0] wr_ptr, rd_ptr;
    logic [DB:0]  head;

    fifo_ptr_ctrl #(
        .W        (W),
        .AF_LEVEL (AF_LEVEL)
    ) u_ctrl (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (rx_done),
        .pop         (rd),
        .clr_ovf     (clr_ovf),
        .wr_en       (wr_en),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .count       (count),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    // Storage is not reset; emptiness alone gates what reaches the outputs.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr] <= {rx_err, d_out};
    end

    always_comb begin
        head   = mem_q[rd_ptr];
        r_data = '0;
        r_err  = 1'b0;
        if (!rx_empty) begin
            r_data = head[DB-1:0];
            r_err  = head[DB];
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Randomized and directed check of uart_rx_fifo_ctrl against a queue-based
// reference model of the FIFO.
module tb_uart_rx_fifo_ctrl;
    import uart_defs::*;

    localparam int DB    = 8;
    localparam int W     = 2;
    localparam int AF    = 3;
    localparam int DEPTH = 1 << W;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DB-1:0] d_out = '0;
    logic          rx_err = 1'b0;
    logic          rx_done = 1'b0;
    logic          rd = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [DB-1:0] r_data;
    logic          r_err;
    logic          rx_empty, rx_full, almost_full, overflow;
    logic [W:0]    count;

    uart_rx_fifo_ctrl #(.DB(DB), .W(W), .AF_LEVEL(AF)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .d_out       (d_out),
        .rx_err      (rx_err),
        .rx_done     (rx_done),
        .rd          (rd),
        .clr_ovf     (clr_ovf),
        .r_data      (r_data),
        .r_err       (r_err),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .count       (count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [DB:0] mq[$];
    bit          m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int         sz;
        logic [1:0] st;
        sz = mq.size();
        st = (sz == 0) ? FIFO_EMPTY : (sz == DEPTH) ? FIFO_FULL : FIFO_PARTIAL;
        chk("count", 32'(count), 32'(sz));
        chk("rx_empty", 32'(rx_empty), 32'(sz == 0));
        chk("rx_full", 32'(rx_full), 32'(sz == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(sz >= AF));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("r_data", 32'(r_data), (sz == 0) ? 32'd0 : 32'(mq[0][DB-1:0]));
        chk("r_err", 32'(r_err), (sz == 0) ? 32'd0 : 32'(mq[0][DB]));
        chk("fsm_state", 32'(dut.u_ctrl.state_q), 32'(st));
    endtask

    task automatic step(input bit done, input bit err, input logic [DB-1:0] d,
                        input bit r, input bit clr);
        bit full, empty, pok, rok;
        rx_done = done; rx_err = err; d_out = d; rd = r; clr_ovf = clr;
        @(posedge clk);
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        pok   = done && (!full || r);
        rok   = r && !empty;
        if (rok) void'(mq.pop_front());
        if (pok) mq.push_back({err, d});
        if (done && !pok) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
        rx_done = 0; rd = 0; clr_ovf = 0;
        check_all();
    endtask

    task automatic push(input logic [DB-1:0] d, input bit err);
        step(1'b1, err, d, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        #12;
        check_all();
        reset_n = 1'b1;

        // single word fall-through
        push(8'hA5, 1'b0);
        pop();

        // fill, overflow, drain, clear
        for (int i = 1; i <= 4; i++) push(8'(i), 1'b0);
        push(8'h05, 1'b0);
        for (int i = 0; i < 4; i++) pop();
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // push+pop while full
        for (int i = 1; i <= 4; i++) push(8'(i), 1'b0);
        step(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) pop();

        // error tag follows its entry
        push(8'h3C, 1'b1);
        push(8'h3D, 1'b0);
        pop();
        pop();

        // drop and clear in the same cycle: set wins
        for (int i = 0; i < 4; i++) push(8'($urandom), 1'b0);
        step(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) pop();

        // pointer wrap at steady count 2
        push(8'h11, 1'b0);
        push(8'h22, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom), 8'($urandom), 1'b1, 1'b0);
        pop();
        pop();
        for (int i = 0; i < 3; i++) pop();

        // random traffic
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 99) < 55), 1'($urandom), 8'($urandom),
                 ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5));

        // asynchronous reset with count=3 and overflow set
        while (mq.size() != 0) pop();
        for (int i = 0; i < 5; i++) push(8'($urandom), 1'b0);
        pop();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        push(8'h9E, 1'b0);
        pop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_ctrl.md
Name: uart_rx_fifo_ctrl

Overview:
- Parametrised receive FIFO between the UART receiver and the bus/interface logic.
- Successor to the single-depth RX buffer:
  - power-of-two depth
  - first-word-fall-through read
  - per-entry frame-error tag
  - full, almost-full and count status
  - sticky overflow
- Data is pushed on the receiver's one-cycle rx_done tick and popped on rd.

Parameters:
- DB, 8: UART data bits per word.
- W, 2: address width; depth = 2**W entries (W >= 1).
- AF_LEVEL, 3: almost_full asserts when count >= AF_LEVEL (1 <= AF_LEVEL <= 2**W).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- d_out  in  DB  received word from UART receiver.
- rx_err  in  1  frame/parity error for the word on d_out; qualified by rx_done.
- rx_done  in  1  one-cycle tick: d_out/rx_err valid, push request.
- rd  in  1  pop request; removes head entry when rx_empty=0.
- clr_ovf  in  1  clears the overflow flag.
- r_data  out  DB  head entry data (FWFT); valid when rx_empty=0.
- r_err  out  1  error tag of head entry.
- rx_empty  out  1  no entries stored.
- rx_full  out  1  2**W entries stored.
- almost_full  out  1  count >= AF_LEVEL.
- overflow  out  1  sticky: a push was dropped.
- count  out  W+1  number of stored entries, 0..2**W.

Behaviour:
- Reset (reset_n low, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - rx_empty=1, rx_full=0, almost_full=0.
  - r_data=0, r_err=0.
  - Storage contents are don't-care.
- Reset mid-operation discards all entries immediately; no push or pop completes in the reset cycle.
- Storage: 2**W entries of DB+1 bits {rx_err, d_out}; write port synchronous; read is the mux of mem[rd_ptr].
- r_data/r_err:
  - Forced to 0 while rx_empty=1.
  - Otherwise equal to the head entry, combinationally from the registered rd_ptr.
  - A word pushed into an empty FIFO appears on r_data the cycle after rx_done (1-cycle latency).
- Pointers are W bits wide and wrap naturally from 2**W-1 to 0. Full and empty are derived from count, not from pointer equality.
- Per-cycle operation, decided from the registered state:
  - push_ok = rx_done & (~rx_full | rd).
  - pop_ok = rd & ~rx_empty.
  - push_ok only: mem[wr_ptr] <= {rx_err,d_out}; wr_ptr++; count++.
  - pop_ok only: rd_ptr++; count--.
  - Both: write, wr_ptr++, rd_ptr++; count unchanged. This includes the full case: pop and push both accepted, no overflow.
  - rd while empty: ignored, no flag.
  - rx_done while full without rd: word dropped, contents unchanged, overflow <= 1.
- overflow:
  - Sticky until clr_ovf.
  - If clr_ovf and a dropping push occur in the same cycle, overflow stays 1 (set wins).
- Status flags are registered, updated with the next-state count:
  - rx_empty = (count_next == 0).
  - rx_full = (count_next == 2**W).
  - almost_full = (count_next >= AF_LEVEL).
- Internal control FSM:
  - States: EMPTY, PARTIAL, FULL, encoded as a shared localparam.
  - EMPTY -> PARTIAL on push_ok.
  - PARTIAL -> EMPTY on pop-only at count=1.
  - PARTIAL -> FULL on push-only at count=2**W-1.
  - FULL -> PARTIAL on pop-only.
  - Simultaneous push+pop holds the state.
  - For W=1 the PARTIAL state is reached only at count=1.
  - The flag outputs must agree with the state at all times; the bench checks this.

Decomposition:
- Shared header (uart_defs):
  - FIFO state encodings EMPTY=2'b00, PARTIAL=2'b01, FULL=2'b10.
  - Default DB.
- One sub-module, fifo_ptr_ctrl (params W, AF_LEVEL):
  - Inputs: push request, pop request, clr_ovf.
  - Owns pointers, count, FSM and flags.
  - Outputs: wr_en, wr_ptr, rd_ptr and the status flags.
- Top level holds the storage array and the output mux.

Test Plan:
- Reset, then push 0xA5 (rx_err=0) -> next cycle rx_empty=0, r_data=0xA5, count=1; rd -> rx_empty=1, r_data=0x00.
- W=2: push 0x01..0x04 -> rx_full=1, almost_full=1 from the 3rd push, count=4. Push 0x05 -> overflow=1, then pop 4 times -> 0x01,0x02,0x03,0x04. clr_ovf -> overflow=0.
- Full FIFO, rx_done(0x55) and rd in the same cycle -> 0x01 popped, count stays 4, overflow=0, tail entry=0x55.
- Push 0x3C with rx_err=1, then 0x3D with rx_err=0 -> r_err=1 with r_data=0x3C; after rd, r_err=0 with r_data=0x3D.
- 20 push/pop pairs at count=2 -> pointers wrap several times and data order is preserved. rd while empty -> count stays 0, no flags change.
- reset_n asserted asynchronously mid-cycle with count=3 -> flags return to reset values immediately, without waiting for a clock edge. After release, the first push appears on r_data.
